dense_layer_multilane: RTL and testbench
========================================

# dense_layer_multilane

Parametrised fully-connected layer for the encoder datapath. Computes `y[j] = act(sat(sum_i x[i]*W[i][j] + b[j]))` for all output neurons, using LANES parallel multiply-accumulate lanes that read input-neuron, weight and bias memories, each with 1-cycle read latency. Results go into an internal output buffer for the next layer and are also streamed out as write strobes. Activation mode is selectable per run: identity, ReLU or leaky ReLU.

## Interface
- INPUTS, 169, input-vector length (weight rows)
- NEURONS, 100, output neurons (weight cols)
- LANES, 2, parallel MAC lanes, ≥1
- INT_W, 10, data integer bits
- FRAC_W, 10, data fraction bits; DATA_W = INT_W+FRAC_W, signed two's complement
- WEIGHT_W, 6, signed weight width
- WEIGHT_FRAC, 4, weight fraction bits
- LEAK_SHIFT, 3, leaky-ReLU negative slope = 2^-LEAK_SHIFT
- IN_ADDR_W, 8 / W_ADDR_W, 15 / N_ADDR_W, 7, address widths

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  begin a pass; sampled only in IDLE or DONE
- act_mode  in  2  0 identity, 1 ReLU, 2 leaky ReLU, 3 treated as ReLU; latched when start is accepted
- in_addr  out  LANES*IN_ADDR_W  per-lane input-neuron address, lane k in bits [k*IN_ADDR_W +: IN_ADDR_W]
- in_data  in  LANES*DATA_W  per-lane input data, valid 1 cycle after address
- w_addr  out  LANES*W_ADDR_W  per-lane weight address
- w_data  in  LANES*WEIGHT_W  per-lane weight data, 1-cycle latency
- bias_addr  out  N_ADDR_W  bias address (= j)
- bias_data  in  DATA_W  bias, 1-cycle latency
- res_we  out  1  one-cycle strobe per finished neuron
- res_addr  out  N_ADDR_W  neuron index of the strobe
- res_data  out  DATA_W  activated result
- rd_addr  in  N_ADDR_W  output buffer read address
- rd_data  out  DATA_W  buffer read data, registered, 1-cycle latency
- busy  out  1  high from the accepted start until DONE
- done  out  1  high in DONE until the next accepted start or reset

## Operation
- GROUPS = ceil(INPUTS/LANES). In group g, lane k handles input i = g*LANES+k.
- Active lane (i < INPUTS):
  - in_addr = i
  - w_addr = i*NEURONS + j (row-major)
- Masked lane (i ≥ INPUTS):
  - both addresses driven 0
  - contribution forced to 0 regardless of returned data
- Product p = in*w at DATA_W+WEIGHT_W bits. Accumulate the full-precision sum of lane products in an accumulator of ACC_W = DATA_W+WEIGHT_W+clog2(INPUTS+1) bits; no intermediate rounding.
- BIAS stage: s = (acc >>> WEIGHT_FRAC) + sign-extended bias. The shift is arithmetic, i.e. truncation toward −inf. Saturate s to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
- ACT stage:
  - identity: s
  - ReLU: max(s,0)
  - leaky: s ≥ 0 ? s : s >>> LEAK_SHIFT
- FSM states:
  - IDLE: start → MAC; j=0, g=0, acc=0, busy=1, mode latched.
  - MAC: GROUPS cycles. Addresses for group g are issued combinationally from counters and g increments. Data from the previous cycle's addresses is accumulated via a 1-cycle valid-delay register. Then → DRAIN.
  - DRAIN: 1 cycle; accumulate the last group.
  - BIAS: 1 cycle; compute and register saturated s. bias_addr = j has been stable since MAC entry.
  - ACT: 1 cycle. Write buffer[j]; pulse res_we with res_addr=j. If j = NEURONS−1 → DONE, else j++, g=0, acc=0 → MAC.
  - DONE: done=1, busy=0. start → new pass, as from IDLE; done drops at the same edge.
- start while busy is ignored.
- rd_data can be read at any time; during a pass, unwritten entries hold the previous pass's values.

## Timing
- Reset values:
  - state IDLE, all counters 0
  - busy=0, done=0, res_we=0, res_addr=0, res_data=0, rd_data=0
  - all address outputs 0
  - buffer contents not cleared
- Each neuron takes GROUPS+3 cycles.
- First res_we: GROUPS+2 edges after the start-sampling edge, rising at the edge that enters ACT.
- done: rises exactly NEURONS*(GROUPS+3) edges after the start-sampling edge.
- Reset mid-pass aborts immediately to IDLE with the reset values above; a partially written buffer is retained.
- start and reset in the same cycle: reset wins.

## Test plan
- Identity. INPUTS=5, LANES=2, NEURONS=3. x=1.0 (1024), W=1.0 (16), b=0, mode 0; input/weight memory beyond index 4 holds 7.0. Expect: buffer = 5120 ×3; res_we at edges 5, 11, 17; done at edge 18; masked lane ignored.
- Negative. Same config, W=−1.0 (−16), b=0.5 (512). Mode 0 → −4608; mode 1 → 0; mode 2 → −576.
- Saturation. x=524287, W=31 → every output 524287. W=−32, mode 0 → −524288.
- Reset mid-pass. Assert reset 2 cycles into neuron 1. Expect: IDLE next edge, busy=0, done=0; buffer[0] keeps its new value. A fresh start then completes normally.
- Restart and ignored start. Pulse start during MAC: no effect, done still at edge 18. In DONE, start with mode 1: done drops next edge and the new results are written.
- Config sweep. LANES=1 and LANES=4 with INPUTS=169, NEURONS=100, random data. Compare against a golden model bit-exactly; check done at NEURONS*(GROUPS+3).

Source files
------------

// File: rtl/dense_layer_multilane.sv
// dense_layer_multilane
// ---------------------------------------------------------------------------
// Fully-connected layer: y[j] = act(sat(sum_i x[i]*W[i][j] + b[j])).
// LANES multiply-accumulate lanes each handle one input neuron per cycle.
// Input, weight and bias memories sit outside this block and answer one
// cycle after their address is presented. Every finished neuron is written
// into an internal output buffer and is also streamed out as a write strobe.
//
// Ports
//   clk, reset      clock; synchronous active-high reset
//   start           begin a pass (sampled only in IDLE or DONE)
//   act_mode        0 identity, 1 ReLU, 2 leaky ReLU, 3 ReLU (latched at start)
//   in_addr/in_data per-lane input-neuron address / data (lane k at slice k)
//   w_addr/w_data   per-lane weight address / data, row-major i*NEURONS+j
//   bias_addr/data  bias address (= current neuron) / data
//   res_we/addr/data one-cycle strobe per finished neuron with its result
//   rd_addr/rd_data output buffer read port, registered (1-cycle latency)
//   busy, done      pass in progress / pass finished
// ---------------------------------------------------------------------------
module dense_layer_multilane #(
    parameter int INPUTS      = 169,
    parameter int NEURONS     = 100,
    parameter int LANES       = 2,
    parameter int INT_W       = 10,
    parameter int FRAC_W      = 10,
    parameter int WEIGHT_W    = 6,
    parameter int WEIGHT_FRAC = 4,
    parameter int LEAK_SHIFT  = 3,
    parameter int IN_ADDR_W   = 8,
    parameter int W_ADDR_W    = 15,
    parameter int N_ADDR_W    = 7
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [1:0]                           act_mode,
    output logic [LANES*IN_ADDR_W-1:0]           in_addr,
    input  logic [LANES*(INT_W+FRAC_W)-1:0]      in_data,
    output logic [LANES*W_ADDR_W-1:0]            w_addr,
    input  logic [LANES*WEIGHT_W-1:0]            w_data,
    output logic [N_ADDR_W-1:0]                  bias_addr,
    input  logic [INT_W+FRAC_W-1:0]              bias_data,
    output logic                                 res_we,
    output logic [N_ADDR_W-1:0]                  res_addr,
    output logic [INT_W+FRAC_W-1:0]              res_data,
    input  logic [N_ADDR_W-1:0]                  rd_addr,
    output logic [INT_W+FRAC_W-1:0]              rd_data,
    output logic                                 busy,
    output logic                                 done
);

    localparam int DATA_W    = INT_W + FRAC_W;
    localparam int PROD_W    = DATA_W + WEIGHT_W;
    localparam int ACC_W     = PROD_W + $clog2(INPUTS + 1);
    localparam int SUM_W     = ACC_W + 1;
    localparam int GROUPS    = (INPUTS + LANES - 1) / LANES;
    localparam int G_W       = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int BUF_DEPTH = 2 ** N_ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAC,
        S_DRAIN,
        S_BIAS,
        S_ACT,
        S_DONE
    } state_t;

    state_t                      r_state;
    state_t                      w_state_next;

    logic [G_W-1:0]              r_g;
    logic [N_ADDR_W-1:0]         r_j;
    logic [31:0]                 r_ibase;   // input index of lane 0 in the current group
    logic [W_ADDR_W-1:0]         r_wbase;   // weight address of lane 0 in the current group
    logic [1:0]                  r_mode;
    logic [LANES-1:0]            r_valid;   // lanes whose data arrives this cycle
    logic signed [ACC_W-1:0]     r_acc;
    logic                        r_res_we;
    logic [N_ADDR_W-1:0]         r_res_addr;
    logic [DATA_W-1:0]           r_res_data;
    logic [DATA_W-1:0]           r_rd_data;
    logic [DATA_W-1:0]           r_buf [BUF_DEPTH];

    logic                        w_start_ok;
    logic                        w_last_group;
    logic                        w_last_neuron;
    logic [LANES-1:0]            w_lane_act;
    logic signed [ACC_W-1:0]     w_term [LANES];
    logic signed [ACC_W-1:0]     w_lane_sum;
    logic signed [ACC_W-1:0]     w_shift;
    logic [SUM_W-1:0]            w_s;
    logic [SUM_W-DATA_W:0]       w_top;
    logic signed [DATA_W-1:0]    w_sat;
    logic signed [DATA_W-1:0]    w_leak;
    logic [DATA_W-1:0]           w_act;

    assign w_start_ok    = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last_group  = (r_g == G_W'(GROUPS - 1));
    assign w_last_neuron = (r_j == N_ADDR_W'(NEURONS - 1));

    // -----------------------------------------------------------------------
    // Per-lane address generation and product
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : gen_lane
            logic [31:0]              w_i;
            logic [W_ADDR_W-1:0]      w_wa;
            logic signed [PROD_W-1:0] w_x_ext;
            logic signed [PROD_W-1:0] w_w_ext;
            logic signed [PROD_W-1:0] w_prod;

            assign w_i  = r_ibase + 32'(gi);
            assign w_wa = r_wbase + W_ADDR_W'(gi * NEURONS);
            // Lanes past the last input row are masked: addresses forced to 0
            // and their returned data never reaches the accumulator.
            assign w_lane_act[gi] = (r_state == S_MAC) && (w_i < 32'(INPUTS));

            assign in_addr[gi*IN_ADDR_W +: IN_ADDR_W] =
                w_lane_act[gi] ? w_i[IN_ADDR_W-1:0] : '0;
            assign w_addr[gi*W_ADDR_W +: W_ADDR_W] =
                w_lane_act[gi] ? w_wa : '0;

            assign w_x_ext = {{WEIGHT_W{in_data[gi*DATA_W + DATA_W - 1]}},
                              in_data[gi*DATA_W +: DATA_W]};
            assign w_w_ext = {{DATA_W{w_data[gi*WEIGHT_W + WEIGHT_W - 1]}},
                              w_data[gi*WEIGHT_W +: WEIGHT_W]};
            assign w_prod  = w_x_ext * w_w_ext;

            assign w_term[gi] = r_valid[gi] ?
                {{(ACC_W - PROD_W){w_prod[PROD_W-1]}}, w_prod} : '0;
        end
    endgenerate

    always_comb begin
        w_lane_sum = '0;
        for (int k = 0; k < LANES; k++) begin
            w_lane_sum = w_lane_sum + w_term[k];
        end
    end

    // -----------------------------------------------------------------------
    // Bias, saturation and activation
    // -----------------------------------------------------------------------
    assign w_shift = r_acc >>> WEIGHT_FRAC;
    assign w_s     = {w_shift[ACC_W-1], w_shift}
                   + {{(SUM_W - DATA_W){bias_data[DATA_W-1]}}, bias_data};
    // In range when every bit from the result sign upward agrees.
    assign w_top   = w_s[SUM_W-1:DATA_W-1];
    assign w_sat   = ((&w_top) || !(|w_top)) ? w_s[DATA_W-1:0] :
                     (w_s[SUM_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                   : {1'b0, {(DATA_W-1){1'b1}}});
    assign w_leak  = w_sat >>> LEAK_SHIFT;

    always_comb begin
        w_act = w_sat;
        case (r_mode)
            2'd0:    w_act = w_sat;
            2'd2:    w_act = w_sat[DATA_W-1] ? w_leak : w_sat;
            default: w_act = w_sat[DATA_W-1] ? '0 : w_sat;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE,
            S_DONE:  if (start) w_state_next = S_MAC;
            S_MAC:   if (w_last_group) w_state_next = S_DRAIN;
            S_DRAIN: w_state_next = S_BIAS;
            S_BIAS:  w_state_next = S_ACT;
            S_ACT:   w_state_next = w_last_neuron ? S_DONE : S_MAC;
            default: w_state_next = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Counters, accumulator and result registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_g        <= '0;
            r_j        <= '0;
            r_ibase    <= '0;
            r_wbase    <= '0;
            r_mode     <= '0;
            r_valid    <= '0;
            r_acc      <= '0;
            r_res_we   <= 1'b0;
            r_res_addr <= '0;
            r_res_data <= '0;
        end else begin
            r_res_we <= 1'b0;
            r_valid  <= w_lane_act;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start_ok) begin
                        r_g     <= '0;
                        r_j     <= '0;
                        r_ibase <= '0;
                        r_wbase <= '0;
                        r_acc   <= '0;
                        r_mode  <= act_mode;
                    end
                end
                S_MAC: begin
                    r_g     <= r_g + G_W'(1);
                    r_ibase <= r_ibase + 32'(LANES);
                    r_wbase <= r_wbase + W_ADDR_W'(LANES * NEURONS);
                    r_acc   <= r_acc + w_lane_sum;
                end
                S_DRAIN: begin
                    r_acc <= r_acc + w_lane_sum;
                end
                S_BIAS: begin
                    // Activation is folded into this registered stage so the
                    // streamed result is valid for the whole strobe cycle.
                    r_res_we   <= 1'b1;
                    r_res_addr <= r_j;
                    r_res_data <= w_act;
                end
                S_ACT: begin
                    if (!w_last_neuron) begin
                        r_j     <= r_j + N_ADDR_W'(1);
                        r_g     <= '0;
                        r_ibase <= '0;
                        r_wbase <= W_ADDR_W'(r_j) + W_ADDR_W'(1);
                        r_acc   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output buffer: not cleared by reset, so a partial pass stays readable.
    always_ff @(posedge clk) begin
        if (!reset && (r_state == S_ACT)) begin
            r_buf[r_j] <= r_res_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_buf[rd_addr];
        end
    end

    assign bias_addr = r_j;
    assign res_we    = r_res_we;
    assign res_addr  = r_res_addr;
    assign res_data  = r_res_data;
    assign rd_data   = r_rd_data;
    assign busy      = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_dense_layer_multilane.sv
// Testbench for dense_layer_multilane: directed small-configuration passes
// (identity, negative/activation modes, saturation, reset, restart) plus a
// LANES=1 / LANES=4 sweep at full size against a reference computation.
module tb_dense_layer_multilane;

    localparam int DW = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- small instance: INPUTS=5, NEURONS=3, LANES=2 --------
    logic               reset_a, start_a;
    logic [1:0]         mode_a;
    logic [15:0]        in_addr_a;
    logic [39:0]        in_data_a;
    logic [29:0]        w_addr_a;
    logic [11:0]        w_data_a;
    logic [6:0]         bias_addr_a;
    logic [DW-1:0]      bias_data_a;
    logic               res_we_a;
    logic [6:0]         res_addr_a;
    logic [DW-1:0]      res_data_a;
    logic [6:0]         rd_addr_a;
    logic [DW-1:0]      rd_data_a;
    logic               busy_a, done_a;

    dense_layer_multilane #(.INPUTS(5), .NEURONS(3), .LANES(2)) u_small (
        .clk(clk), .reset(reset_a), .start(start_a), .act_mode(mode_a),
        .in_addr(in_addr_a), .in_data(in_data_a),
        .w_addr(w_addr_a), .w_data(w_data_a),
        .bias_addr(bias_addr_a), .bias_data(bias_data_a),
        .res_we(res_we_a), .res_addr(res_addr_a), .res_data(res_data_a),
        .rd_addr(rd_addr_a), .rd_data(rd_data_a),
        .busy(busy_a), .done(done_a)
    );

    logic signed [DW-1:0] x_s [256];
    logic signed [5:0]    w_s [32768];
    logic signed [DW-1:0] b_s [128];

    // Lane 1 never legitimately addresses 0, so at address 0 it is a masked
    // lane: hand back junk (7.0 / max weight) that must not be accumulated.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            in_data_a[k*DW +: DW] <= (k == 1 && in_addr_a[k*8 +: 8] == 8'd0)
                                     ? 20'sd7168 : x_s[in_addr_a[k*8 +: 8]];
            w_data_a[k*6 +: 6]    <= (k == 1 && w_addr_a[k*15 +: 15] == 15'd0)
                                     ? 6'sd31 : w_s[w_addr_a[k*15 +: 15]];
        end
        bias_data_a <= b_s[bias_addr_a];
    end

    // ---------------- sweep instances: INPUTS=169, NEURONS=100 ------------
    logic               reset_b, start_b;
    logic [1:0]         mode_b;
    logic [7:0]         in_addr_b;   logic [DW-1:0]  in_data_b;
    logic [14:0]        w_addr_b;    logic [5:0]     w_data_b;
    logic [6:0]         bias_addr_b; logic [DW-1:0]  bias_data_b;
    logic               res_we_b;    logic [6:0]     res_addr_b;
    logic [DW-1:0]      res_data_b;  logic [DW-1:0]  rd_data_b;
    logic               busy_b, done_b;

    logic [31:0]        in_addr_c;   logic [4*DW-1:0] in_data_c;
    logic [59:0]        w_addr_c;    logic [23:0]     w_data_c;
    logic [6:0]         bias_addr_c; logic [DW-1:0]   bias_data_c;
    logic               res_we_c;    logic [6:0]      res_addr_c;
    logic [DW-1:0]      res_data_c;  logic [DW-1:0]   rd_data_c;
    logic               busy_c, done_c;
    logic [6:0]         rd_addr_bc;

    dense_layer_multilane #(.INPUTS(169), .NEURONS(100), .LANES(1)) u_l1 (
        .clk(clk), .reset(reset_b), .start(start_b), .act_mode(mode_b),
        .in_addr(in_addr_b), .in_data(in_data_b),
        .w_addr(w_addr_b), .w_data(w_data_b),
        .bias_addr(bias_addr_b), .bias_data(bias_data_b),
        .res_we(res_we_b), .res_addr(res_addr_b), .res_data(res_data_b),
        .rd_addr(rd_addr_bc), .rd_data(rd_data_b),
        .busy(busy_b), .done(done_b)
    );

    dense_layer_multilane #(.INPUTS(169), .NEURONS(100), .LANES(4)) u_l4 (
        .clk(clk), .reset(reset_b), .start(start_b), .act_mode(mode_b),
        .in_addr(in_addr_c), .in_data(in_data_c),
        .w_addr(w_addr_c), .w_data(w_data_c),
        .bias_addr(bias_addr_c), .bias_data(bias_data_c),
        .res_we(res_we_c), .res_addr(res_addr_c), .res_data(res_data_c),
        .rd_addr(rd_addr_bc), .rd_data(rd_data_c),
        .busy(busy_c), .done(done_c)
    );

    logic signed [DW-1:0] xb [256];
    logic signed [5:0]    wb [32768];
    logic signed [DW-1:0] bb [128];
    int                   exp_big [100];

    always @(posedge clk) begin
        in_data_b   <= xb[in_addr_b];
        w_data_b    <= wb[w_addr_b];
        bias_data_b <= bb[bias_addr_b];
        for (int k = 0; k < 4; k++) begin
            in_data_c[k*DW +: DW] <= xb[in_addr_c[k*8 +: 8]];
            w_data_c[k*6 +: 6]    <= wb[w_addr_c[k*15 +: 15]];
        end
        bias_data_c <= bb[bias_addr_c];
    end

    // ---------------- helpers ---------------------------------------------
    task automatic check(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic set_small(input int xv, input int wv, input int bv);
        for (int i = 0; i < 256; i++)   x_s[i] = (i < 5)  ? 20'(xv) : 20'sd7168;
        for (int i = 0; i < 32768; i++) w_s[i] = (i < 15) ? 6'(wv)  : 6'sd31;
        for (int i = 0; i < 128; i++)   b_s[i] = 20'(bv);
    endtask

    task automatic read_buf(input string tag, input int addr, input int expv);
        @(negedge clk);
        rd_addr_a = 7'(addr);
        @(posedge clk);
        #1;
        check(tag, int'($signed(rd_data_a)), expv);
    endtask

    // One full pass on the small instance. Edges are counted from the edge
    // that samples start (edge 0); GROUPS=3 so strobes land on 5, 11, 17
    // and done on 18. With pulse set, start is raised again during MAC.
    task automatic run_pass(input logic [1:0] mode, input int expv, input bit pulse);
        int  n;
        bit  fin;
        n   = 0;
        fin = 0;
        @(negedge clk);
        mode_a  = mode;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        for (int e = 1; e <= 40 && !fin; e++) begin
            @(posedge clk);
            #1;
            if (pulse) start_a = (e == 2);
            if (e == 1) begin
                check("busy_after_start", int'(busy_a), 1);
                check("done_after_start", int'(done_a), 0);
            end
            if (res_we_a) begin
                check("res_we_edge", e, 5 + 6 * n);
                check("res_addr", int'(res_addr_a), n);
                check("res_data", int'($signed(res_data_a)), expv);
                n++;
            end
            if (done_a) begin
                fin = 1;
                check("done_edge", e, 18);
                check("busy_in_done", int'(busy_a), 0);
            end
        end
        start_a = 1'b0;
        check("pass_completed", int'(fin), 1);
        check("strobe_count", n, 3);
    endtask

    function automatic int golden(input int j, input int mode);
        longint acc;
        longint s;
        acc = 0;
        for (int i = 0; i < 169; i++) acc += longint'(xb[i]) * longint'(wb[i*100 + j]);
        s = (acc >>> 4) + longint'(bb[j]);
        if (s > 524287)  s = 524287;
        if (s < -524288) s = -524288;
        if (mode == 0) return int'(s);
        if (mode == 2) return (s < 0) ? int'(s >>> 3) : int'(s);
        return (s < 0) ? 0 : int'(s);
    endfunction

    // ---------------- directed sequence ------------------------------------
    initial begin
        int  nb, nc;
        bit  db, dc;
        int  t;

        reset_a = 1'b1; start_a = 1'b0; mode_a = 2'd0; rd_addr_a = '0;
        reset_b = 1'b1; start_b = 1'b0; mode_b = 2'd2; rd_addr_bc = '0;
        set_small(1024, 16, 0);
        for (int i = 0; i < 256; i++) begin
            t = int'($urandom_range(0, 8191));
            xb[i] = (i < 169) ? 20'(t - 4096) : 20'sd0;
        end
        xb[7]  = 20'sd524287;
        xb[90] = -20'sd524288;
        for (int i = 0; i < 32768; i++) wb[i] = (i < 16900) ? 6'($urandom_range(0, 63)) : 6'sd0;
        for (int i = 0; i < 128; i++)   bb[i] = 20'($urandom);
        for (int j = 0; j < 100; j++)   exp_big[j] = golden(j, 2);

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",     int'(busy_a), 0);
        check("rst_done",     int'(done_a), 0);
        check("rst_res_we",   int'(res_we_a), 0);
        check("rst_res_addr", int'(res_addr_a), 0);
        check("rst_res_data", int'(res_data_a), 0);
        check("rst_rd_data",  int'(rd_data_a), 0);
        check("rst_in_addr",  int'(in_addr_a), 0);
        check("rst_w_addr",   int'(w_addr_a), 0);
        check("rst_bias_addr", int'(bias_addr_a), 0);
        reset_a = 1'b0;
        reset_b = 1'b0;

        // Identity, with an ignored start pulse during MAC.
        run_pass(2'd0, 5120, 1'b1);
        read_buf("buf0_identity", 0, 5120);
        read_buf("buf2_identity", 2, 5120);

        // Negative weights, positive bias, each activation mode (restart from DONE).
        set_small(1024, -16, 512);
        run_pass(2'd0, -4608, 1'b0);
        run_pass(2'd1, 0, 1'b0);
        read_buf("buf1_relu", 1, 0);
        run_pass(2'd2, -576, 1'b0);
        run_pass(2'd3, 0, 1'b0);

        // Saturation both ways.
        set_small(524287, 31, 0);
        run_pass(2'd0, 524287, 1'b0);
        set_small(524287, -32, 0);
        run_pass(2'd0, -524288, 1'b0);

        // Reset two cycles into neuron 1 (neuron 1 enters MAC at edge 6).
        set_small(1024, 16, 0);
        @(negedge clk);
        mode_a  = 2'd0;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        reset_a = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_busy",     int'(busy_a), 0);
        check("midrst_done",     int'(done_a), 0);
        check("midrst_res_we",   int'(res_we_a), 0);
        check("midrst_in_addr",  int'(in_addr_a), 0);
        check("midrst_w_addr",   int'(w_addr_a), 0);
        check("midrst_bias_addr", int'(bias_addr_a), 0);
        reset_a = 1'b0;
        read_buf("midrst_buf0_new", 0, 5120);
        read_buf("midrst_buf1_old", 1, -524288);

        // Start and reset together: reset wins.
        @(negedge clk);
        reset_a = 1'b1;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        check("rst_start_busy", int'(busy_a), 0);
        reset_a = 1'b0;
        start_a = 1'b0;

        // Fresh pass after reset completes normally.
        set_small(1024, -16, 512);
        run_pass(2'd2, -576, 1'b0);
        read_buf("buf2_after_reset", 2, -576);

        // Full-size sweep, LANES=1 and LANES=4 side by side, leaky mode.
        nb = 0; nc = 0; db = 0; dc = 0;
        @(negedge clk);
        start_b = 1'b1;
        @(posedge clk);
        #1;
        start_b = 1'b0;
        for (int e = 1; e <= 17400 && !(db && dc); e++) begin
            @(posedge clk);
            #1;
            if (res_we_b) begin
                check("l1_res_addr", int'(res_addr_b), nb);
                check("l1_res_data", int'($signed(res_data_b)), (nb < 100) ? exp_big[nb] : 32'h7fffffff);
                nb++;
            end
            if (res_we_c) begin
                check("l4_res_addr", int'(res_addr_c), nc);
                check("l4_res_data", int'($signed(res_data_c)), (nc < 100) ? exp_big[nc] : 32'h7fffffff);
                nc++;
            end
            if (done_b && !db) begin
                db = 1;
                check("l1_done_edge", e, 100 * (169 + 3));
            end
            if (done_c && !dc) begin
                dc = 1;
                check("l4_done_edge", e, 100 * (43 + 3));
            end
        end
        check("l1_finished", int'(db), 1);
        check("l4_finished", int'(dc), 1);
        check("l1_strobes", nb, 100);
        check("l4_strobes", nc, 100);

        @(negedge clk);
        rd_addr_bc = 7'd57;
        @(posedge clk);
        #1;
        check("l1_buf57", int'($signed(rd_data_b)), exp_big[57]);
        check("l4_buf57", int'($signed(rd_data_c)), exp_big[57]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
